// File: rtl/io_pkg.sv
// Shared I/O definitions: device select codes and load/store size codes
// used by both the input and output buffers.
package io_pkg;

  localparam logic [3:0] IO_DEV_SW   = 4'h0;
  localparam logic [3:0] IO_DEV_BTN  = 4'h1;
  localparam logic [3:0] IO_DEV_EDGE = 4'h2;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } ld_funct3_e;

  localparam logic [2:0] F3_SW = 3'b010;

endpackage

// File: rtl/input_buffer_if.sv
// CPU-side I/O bus for the input buffer: address, size code, store data,
// load/store enables and the returned load data.
interface input_buffer_if;
  import io_pkg::*;

  logic [31:0] io_addr;
  logic [2:0]  funct3;
  logic [31:0] st_data;
  logic        io_rden;
  logic        io_wren;
  logic [31:0] ld_data;

  modport master (
    output io_addr, funct3, st_data, io_rden, io_wren,
    input  ld_data
  );

  modport slave (
    input  io_addr, funct3, st_data, io_rden, io_wren,
    output ld_data
  );

endinterface

// File: rtl/io_debounce.sv
// One push button: polarity fix, 2-FF synchroniser and optional debounce.
// Define INPUT_BUFFER_DEBOUNCE_EN to enable the stable-sample counter.
module io_debounce
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn_raw,
  output logic o_stable,
  output logic o_rise
);

  logic w_level;
  logic r_sync1;
  logic r_sync2;
  logic r_stable;

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end

  assign w_level = BTN_ACTIVE_LOW ? ~i_btn_raw : i_btn_raw;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= w_level;
      r_sync2 <= r_sync1;
    end
  end

`ifdef INPUT_BUFFER_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          w_accept;

  assign w_accept = (r_sync2 != r_stable) && (r_cnt == CNT_LAST);

  // Any sample that agrees with the accepted level restarts the count.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (r_sync2 == r_stable) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_stable <= r_sync2;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_rise = w_accept && r_sync2;
`else
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_stable <= 1'b0;
    end else begin
      r_stable <= r_sync2;
    end
  end

  assign o_rise = r_sync2 && !r_stable;
`endif

  assign o_stable = r_stable;

endmodule

// File: rtl/input_buffer.sv
// Memory-mapped input device: switches, debounced buttons and press capture.
// Define INPUT_BUFFER_DEBOUNCE_EN to enable per-button debounce counters.
module input_buffer
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_io_sw,
  input  logic [3:0]  i_io_btn,
  input  logic [31:0] i_io_addr,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_st_data,
  input  logic        f_io_rden,
  input  logic        f_io_wren,
  output logic [31:0] o_ld_data
);

  logic [31:0] r_sw_sync1;
  logic [31:0] r_sw_sync2;
  logic [3:0]  w_btn_stable;
  logic [3:0]  w_btn_rise;
  logic [3:0]  w_edge_clr;
  logic [3:0]  r_edge_cap;
  logic [3:0]  w_dev;
  logic [31:0] w_src;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_unused;

  assign w_dev    = i_io_addr[15:12];
  assign w_unused = ^{i_io_addr[31:16], i_io_addr[11:2], i_st_data[31:4]};

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sw_sync1 <= '0;
      r_sw_sync2 <= '0;
    end else begin
      r_sw_sync1 <= i_io_sw;
      r_sw_sync2 <= r_sw_sync1;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    io_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_debounce (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_btn_raw(i_io_btn[gi]),
      .o_stable (w_btn_stable[gi]),
      .o_rise   (w_btn_rise[gi])
    );
  end

  assign w_edge_clr = (f_io_wren && (w_dev == IO_DEV_EDGE) && (i_funct3 == F3_SW))
                      ? i_st_data[3:0] : 4'b0000;

  // Set is applied after clear so a press landing with a clear is kept.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_edge_cap <= '0;
    end else begin
      r_edge_cap <= (r_edge_cap & ~w_edge_clr) | w_btn_rise;
    end
  end

  always_comb begin
    w_src = '0;
    case (w_dev)
      IO_DEV_SW:   w_src = r_sw_sync2;
      IO_DEV_BTN:  w_src = {28'b0, w_btn_stable};
      IO_DEV_EDGE: w_src = {28'b0, r_edge_cap};
      default:     w_src = '0;
    endcase
  end

  always_comb begin
    w_byte = w_src[7:0];
    case (i_io_addr[1:0])
      2'd0:    w_byte = w_src[7:0];
      2'd1:    w_byte = w_src[15:8];
      2'd2:    w_byte = w_src[23:16];
      default: w_byte = w_src[31:24];
    endcase
    w_half = i_io_addr[1] ? w_src[31:16] : w_src[15:0];
  end

  always_comb begin
    o_ld_data = '0;
    if (f_io_rden) begin
      case (i_funct3)
        F3_LB:   o_ld_data = {{24{w_byte[7]}}, w_byte};
        F3_LH:   o_ld_data = {{16{w_half[15]}}, w_half};
        F3_LW:   o_ld_data = w_src;
        F3_LBU:  o_ld_data = {24'b0, w_byte};
        F3_LHU:  o_ld_data = {16'b0, w_half};
        default: o_ld_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_input_buffer.sv
// Self-checking bench for input_buffer (DEBOUNCE_CYCLES=4, active-low buttons);
// follows the INPUT_BUFFER_DEBOUNCE_EN setting of the build.
module tb_input_buffer;
  import io_pkg::*;

  localparam int DEB = 4;
`ifdef INPUT_BUFFER_DEBOUNCE_EN
  localparam int WIN = DEB;
`else
  localparam int WIN = 1;
`endif
  localparam int LAT = 2 + WIN;

  localparam logic [31:0] A_SW   = 32'h1001_0000;
  localparam logic [31:0] A_BTN  = 32'h1001_1000;
  localparam logic [31:0] A_EDGE = 32'h1001_2000;

  logic        clk = 1'b0;
  logic        rstN;
  logic [31:0] ioSw;
  logic [3:0]  ioBtn;
  int          checks = 0;
  int          failures = 0;

  input_buffer_if bus ();

  input_buffer #(
    .DEBOUNCE_CYCLES(DEB),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .i_clk    (clk),
    .i_reset  (rstN),
    .i_io_sw  (ioSw),
    .i_io_btn (ioBtn),
    .i_io_addr(bus.io_addr),
    .i_funct3 (bus.funct3),
    .i_st_data(bus.st_data),
    .f_io_rden(bus.io_rden),
    .f_io_wren(bus.io_wren),
    .o_ld_data(bus.ld_data)
  );

  always #5 clk = ~clk;

  // Reference model: a button level is accepted once WIN consecutive
  // synchronised samples (two edges old) all disagree with the current level.
  logic [3:0]  btnHist [0:15];
  logic [31:0] swHist  [0:1];
  logic [3:0]  mStable;
  logic [3:0]  mEdge;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < 16; i++) btnHist[i] = '0;
      swHist[0] = '0;
      swHist[1] = '0;
      mStable = '0;
      mEdge = '0;
    end else begin : mUpdate
      logic [3:0] rise;
      logic [3:0] clr;
      int disagree;
      for (int i = 15; i > 0; i--) btnHist[i] = btnHist[i-1];
      btnHist[0] = ~ioBtn;
      swHist[1] = swHist[0];
      swHist[0] = ioSw;
      rise = '0;
      for (int b = 0; b < 4; b++) begin
        disagree = 0;
        for (int j = 2; j < WIN + 2; j++)
          if (btnHist[j][b] != mStable[b]) disagree++;
        if (disagree == WIN) begin
          mStable[b] = ~mStable[b];
          rise[b] = mStable[b];
        end
      end
      clr = (bus.io_wren && bus.io_addr[15:12] == 4'h2 && bus.funct3 == 3'b010)
            ? bus.st_data[3:0] : 4'b0;
      mEdge = (mEdge & ~clr) | rise;
    end
  end

  function automatic logic [31:0] modelLoad();
    logic [31:0] word;
    logic [7:0]  b;
    logic [15:0] h;
    if (!bus.io_rden) return 32'h0;
    case (bus.io_addr[15:12])
      4'h0:    word = swHist[1];
      4'h1:    word = {28'b0, mStable};
      4'h2:    word = {28'b0, mEdge};
      default: word = 32'h0;
    endcase
    b = 8'(word >> (8 * int'(bus.io_addr[1:0])));
    h = 16'(word >> (16 * int'(bus.io_addr[1])));
    case (bus.funct3)
      3'b000:  return 32'($signed(b));
      3'b001:  return 32'($signed(h));
      3'b010:  return word;
      3'b100:  return 32'(b);
      3'b101:  return 32'(h);
      default: return 32'h0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] expected);
    checks++;
    if (bus.ld_data !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, bus.ld_data, expected);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, modelLoad());
  endtask

  task automatic applyStimulus(input logic rden, input logic wren, input logic [31:0] addr,
                               input logic [2:0] f3, input logic [31:0] data);
    bus.io_rden = rden;
    bus.io_wren = wren;
    bus.io_addr = addr;
    bus.funct3  = f3;
    bus.st_data = data;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doLoad(input string name, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] expected);
    applyStimulus(1'b1, 1'b0, addr, f3, 32'h0);
    checkOutput(name, expected);
    checkModel({name, "/model"});
  endtask

  task automatic doStore(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] data);
    applyStimulus(1'b0, 1'b1, addr, f3, data);
    tick();
    applyStimulus(1'b0, 1'b0, addr, f3, 32'h0);
  endtask

  typedef struct {
    string       name;
    logic        rden;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int bsel;
    logic [31:0] addr;

    vecs.push_back('{"lw_sw",     1'b1, 32'h1001_0000, 3'b010, 32'h0003_A5C3});
    vecs.push_back('{"lb_off0",   1'b1, 32'h1001_0000, 3'b000, 32'hFFFF_FFC3});
    vecs.push_back('{"lbu_off1",  1'b1, 32'h1001_0001, 3'b100, 32'h0000_00A5});
    vecs.push_back('{"lh_off2",   1'b1, 32'h1001_0002, 3'b001, 32'h0000_0003});
    vecs.push_back('{"lb_off1",   1'b1, 32'h1001_0001, 3'b000, 32'hFFFF_FFA5});
    vecs.push_back('{"lb_off3",   1'b1, 32'h1001_0003, 3'b000, 32'h0000_0000});
    vecs.push_back('{"lbu_off0",  1'b1, 32'h1001_0000, 3'b100, 32'h0000_00C3});
    vecs.push_back('{"lh_off0",   1'b1, 32'h1001_0000, 3'b001, 32'hFFFF_A5C3});
    vecs.push_back('{"lhu_off0",  1'b1, 32'h1001_0000, 3'b101, 32'h0000_A5C3});
    vecs.push_back('{"lh_mis3",   1'b1, 32'h1001_0003, 3'b001, 32'h0000_0003});
    vecs.push_back('{"lw_mis3",   1'b1, 32'h1001_0003, 3'b010, 32'h0003_A5C3});
    vecs.push_back('{"hi_addr",   1'b1, 32'hFFFF_0002, 3'b101, 32'h0000_0003});
    vecs.push_back('{"rden_off",  1'b0, 32'h1001_0000, 3'b010, 32'h0000_0000});
    vecs.push_back('{"dev5",      1'b1, 32'h1001_5000, 3'b010, 32'h0000_0000});
    vecs.push_back('{"f3_011",    1'b1, 32'h1001_0000, 3'b011, 32'h0000_0000});
    vecs.push_back('{"f3_111",    1'b1, 32'h1001_0000, 3'b111, 32'h0000_0000});
    vecs.push_back('{"lw_btn0",   1'b1, 32'h1001_1000, 3'b010, 32'h0000_0000});
    vecs.push_back('{"lw_edge0",  1'b1, 32'h1001_2000, 3'b010, 32'h0000_0000});

    rstN  = 1'b0;
    ioSw  = 32'h0003_A5C3;
    ioBtn = 4'hF;
    applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
    repeat (3) tick();
    doLoad("rst_sw",   A_SW,   F3_LW, 32'h0);
    doLoad("rst_btn",  A_BTN,  F3_LW, 32'h0);
    doLoad("rst_edge", A_EDGE, F3_LW, 32'h0);

    rstN = 1'b1;
    repeat (3) tick();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rden, 1'b0, vecs[i].addr, vecs[i].f3, 32'h0);
      checkOutput(vecs[i].name, vecs[i].exp);
      checkModel({vecs[i].name, "/model"});
    end

    // Clean press on button 0: accepted exactly LAT edges after the change.
    ioBtn[0] = 1'b0;
    for (int c = 1; c <= LAT; c++) begin
      tick();
      doLoad("press_lat", A_BTN, F3_LW, (c == LAT) ? 32'h1 : 32'h0);
    end
    repeat (10 - LAT) tick();
    doLoad("press_btn",  A_BTN,  F3_LW, 32'h1);
    doLoad("press_edge", A_EDGE, F3_LW, 32'h1);
    ioBtn[0] = 1'b1;
    repeat (LAT + 1) tick();
    doLoad("release_btn",  A_BTN,  F3_LW, 32'h0);
    doLoad("release_edge", A_EDGE, F3_LW, 32'h1);

    ioBtn[1] = 1'b0;
    repeat (3) tick();
    ioBtn[1] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      applyStimulus(1'b1, 1'b0, A_BTN, F3_LW, 32'h0);
      checkModel("glitch_track");
    end
`ifdef INPUT_BUFFER_DEBOUNCE_EN
    doLoad("glitch_btn",  A_BTN,  F3_LW, 32'h0);
    doLoad("glitch_edge", A_EDGE, F3_LW, 32'h1);
`else
    doLoad("glitch_btn", A_BTN, F3_LW, 32'h0);
    doStore(A_EDGE, F3_SW, 32'h2);
    doLoad("glitch_edge", A_EDGE, F3_LW, 32'h1);
`endif

    doStore(A_EDGE, 3'b000, 32'hF);
    doLoad("sb_noclear", A_EDGE, F3_LW, 32'h1);
    doStore(A_BTN, F3_SW, 32'hF);
    doLoad("wrongdev_noclear", A_EDGE, F3_LW, 32'h1);
    doStore(A_EDGE, F3_SW, 32'h1);
    doLoad("sw_clear", A_EDGE, F3_LW, 32'h0);

    // Clear of bit 2 lands on the very edge button 2 becomes stable.
    ioBtn[2] = 1'b0;
    for (int c = 1; c < LAT; c++) begin
      tick();
      doLoad("prio_wait", A_BTN, F3_LW, 32'h0);
    end
    applyStimulus(1'b0, 1'b1, A_EDGE, F3_SW, 32'h4);
    tick();
    doLoad("prio_btn",  A_BTN,  F3_LW, 32'h4);
    doLoad("prio_edge", A_EDGE, F3_LW, 32'h4);
    doStore(A_EDGE, F3_SW, 32'h4);
    doLoad("prio_clear_later", A_EDGE, F3_LW, 32'h0);
    ioBtn[2] = 1'b1;
    repeat (LAT + 1) tick();

    ioBtn[3] = 1'b0;
    repeat (4) tick();
    rstN = 1'b0;
    doLoad("midrst_sw",   A_SW,   F3_LW, 32'h0);
    doLoad("midrst_btn",  A_BTN,  F3_LW, 32'h0);
    doLoad("midrst_edge", A_EDGE, F3_LW, 32'h0);
    repeat (2) tick();
    rstN = 1'b1;
    for (int c = 1; c <= LAT; c++) begin
      tick();
      doLoad("midrst_lat", A_BTN, F3_LW, (c == LAT) ? 32'h8 : 32'h0);
    end
    doLoad("midrst_edge2", A_EDGE, F3_LW, 32'h8);
    ioBtn[3] = 1'b1;

    for (int c = 0; c < 400; c++) begin
      tick();
      if ($urandom_range(7) == 0) begin
        bsel = $urandom_range(3);
        ioBtn[bsel] = ~ioBtn[bsel];
      end
      if ($urandom_range(15) == 0) ioSw = $urandom();
      addr = $urandom();
      addr[15:12] = 4'($urandom_range(3));
      if ($urandom_range(9) == 0)
        applyStimulus(1'($urandom_range(1)), 1'b1, addr,
                      ($urandom_range(1) == 0) ? F3_SW : 3'($urandom_range(7)), $urandom());
      else
        applyStimulus(($urandom_range(4) != 0), 1'b0, addr, 3'($urandom_range(7)), 32'h0);
      checkModel("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
